// File: rtl/tm1638_scan_ctrl.sv
// TM1638 frame sequencer: writes mode, 16 display bytes and control, then reads 4 key bytes
// over STB/CLK/DIO, repeating after a programmable idle gap.
//
// state   | meaning
// IDLE    | waiting for enable, latches inputs at frame start
// T_MODE  | sending 0x40 (auto-increment write)
// GAP     | stb high for 2 cycles between transactions
// T_DATA  | sending 0xC0 and the 16 display bytes
// T_CTRL  | sending display control byte
// T_RD    | sending 0x42, bus turnaround, reading 32 key bits
// DONE    | publishing keys with a one-cycle keys_valid
// WAITGAP | idle gap between frames
module tm1638_scan_ctrl #(
  parameter logic [15:0] GAP_CYCLES = 16'd5000,
  parameter int          TWAIT      = 2
) (
  input  logic         drvclk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         display_on,
  input  logic [2:0]   brightness,
  input  logic [127:0] seg_data,
  output logic [31:0]  keys,
  output logic         keys_valid,
  output logic         busy,
  output logic         stb,
  output logic         dev_clk,
  output logic         dio_out,
  output logic         dio_oe,
  input  logic         dio_in
);

  typedef enum logic [2:0] {
    IDLE, T_MODE, GAP, T_DATA, T_CTRL, T_RD, DONE, WAITGAP
  } state_t;

  typedef enum logic [1:0] {RD_CMD, RD_WAIT, RD_BITS} rd_t;

  localparam logic [7:0] TWAIT_M1 = 8'(TWAIT - 1);

  state_t         state;
  state_t         nxt;
  rd_t            rd_sub;
  logic [127:0]   seg_l;
  logic [7:0]     ctrl_l;
  logic [135:0]   tx_sr;
  logic [31:0]    rx_sr;
  logic [7:0]     bits_left;
  logic [7:0]     wcnt;
  logic [15:0]    gap_cnt;
  logic           gap_hold;
  logic           ph;
  logic           wr_phase;

  // All command/data bytes share one LSB-first write engine, including the read command.
  assign wr_phase = (state == T_MODE) || (state == T_DATA) || (state == T_CTRL) ||
                    ((state == T_RD) && (rd_sub == RD_CMD));

  always_ff @(posedge drvclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      nxt        <= T_DATA;
      rd_sub     <= RD_CMD;
      stb        <= 1'b1;
      dev_clk    <= 1'b1;
      dio_oe     <= 1'b0;
      dio_out    <= 1'b1;
      keys       <= 32'd0;
      keys_valid <= 1'b0;
      busy       <= 1'b0;
      gap_cnt    <= 16'd0;
      gap_hold   <= 1'b0;
      ph         <= 1'b0;
      bits_left  <= 8'd0;
      wcnt       <= 8'd0;
      tx_sr      <= 136'd0;
      rx_sr      <= 32'd0;
      seg_l      <= 128'd0;
      ctrl_l     <= 8'd0;
    end else begin
      keys_valid <= 1'b0;
      if (wr_phase) begin
        if (ph) begin
          dev_clk   <= 1'b1;
          ph        <= 1'b0;
          tx_sr     <= tx_sr >> 1;
          bits_left <= bits_left - 8'd1;
        end else if (bits_left != 8'd0) begin
          dev_clk <= 1'b0;
          dio_out <= tx_sr[0];
          ph      <= 1'b1;
        end else if (state == T_RD) begin
          dio_oe  <= 1'b0;
          dio_out <= 1'b1;
          wcnt    <= TWAIT_M1;
          rd_sub  <= RD_WAIT;
        end else begin
          stb      <= 1'b1;
          dio_oe   <= 1'b0;
          dio_out  <= 1'b1;
          gap_hold <= 1'b1;
          state    <= GAP;
          case (state)
            T_MODE:  nxt <= T_DATA;
            T_DATA:  nxt <= T_CTRL;
            default: nxt <= T_RD;
          endcase
        end
      end else begin
        case (state)
          IDLE: begin
            if (enable) begin
              seg_l     <= seg_data;
              ctrl_l    <= {4'h8, display_on, brightness};
              busy      <= 1'b1;
              stb       <= 1'b0;
              dio_oe    <= 1'b1;
              tx_sr     <= 136'h40;
              bits_left <= 8'd8;
              ph        <= 1'b0;
              state     <= T_MODE;
            end
          end
          GAP: begin
            if (gap_hold) begin
              gap_hold <= 1'b0;
            end else begin
              stb       <= 1'b0;
              dio_oe    <= 1'b1;
              ph        <= 1'b0;
              bits_left <= 8'd8;
              rd_sub    <= RD_CMD;
              state     <= nxt;
              case (nxt)
                T_DATA: begin
                  tx_sr     <= {seg_l, 8'hC0};
                  bits_left <= 8'd136;
                end
                T_CTRL:  tx_sr <= {128'd0, ctrl_l};
                default: tx_sr <= 136'h42;
              endcase
            end
          end
          T_RD: begin
            if (rd_sub == RD_WAIT) begin
              // The last wait cycle also drops dev_clk for the first read bit.
              if (wcnt == 8'd0) begin
                dev_clk   <= 1'b0;
                ph        <= 1'b1;
                bits_left <= 8'd32;
                rd_sub    <= RD_BITS;
              end else begin
                wcnt <= wcnt - 8'd1;
              end
            end else begin
              if (ph) begin
                dev_clk   <= 1'b1;
                ph        <= 1'b0;
                rx_sr     <= {dio_in, rx_sr[31:1]};
                bits_left <= bits_left - 8'd1;
              end else if (bits_left != 8'd0) begin
                dev_clk <= 1'b0;
                ph      <= 1'b1;
              end else begin
                stb   <= 1'b1;
                state <= DONE;
              end
            end
          end
          DONE: begin
            keys       <= rx_sr;
            keys_valid <= 1'b1;
            gap_cnt    <= GAP_CYCLES;
            state      <= WAITGAP;
          end
          WAITGAP: begin
            busy <= 1'b0;
            if (gap_cnt == 16'd0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tm1638_scan_ctrl.sv
// Scoreboard bench for tm1638_scan_ctrl: a bus monitor decodes each STB transaction and a
// key monitor checks keys_valid, both against frames queued by the randomized stimulus.
`timescale 1ns/1ps
module tb_tm1638_scan_ctrl;

  localparam logic [15:0] GAP_A   = 16'd20;
  localparam int          TWAIT_A = 2;

  logic         drvclk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         display_on;
  logic [2:0]   brightness;
  logic [127:0] seg_data;
  logic [31:0]  keys_a, keys_b;
  logic         keys_valid_a, keys_valid_b;
  logic         busy_a, busy_b;
  logic         stb_a, stb_b;
  logic         dev_clk_a, dev_clk_b;
  logic         dio_out_a, dio_out_b;
  logic         dio_oe_a, dio_oe_b;
  logic         dio_in_a = 1'b1;
  logic         dio_in_b = 1'b1;

  always #5 drvclk = ~drvclk;

  tm1638_scan_ctrl #(.GAP_CYCLES(GAP_A), .TWAIT(TWAIT_A)) u_dut (
    .drvclk(drvclk), .reset_n(reset_n), .enable(enable), .display_on(display_on),
    .brightness(brightness), .seg_data(seg_data), .keys(keys_a), .keys_valid(keys_valid_a),
    .busy(busy_a), .stb(stb_a), .dev_clk(dev_clk_a), .dio_out(dio_out_a), .dio_oe(dio_oe_a),
    .dio_in(dio_in_a)
  );

  // Zero-gap instance, back-to-back frames, board pulls DIO high.
  tm1638_scan_ctrl #(.GAP_CYCLES(16'd0), .TWAIT(1)) u_dut0 (
    .drvclk(drvclk), .reset_n(reset_n), .enable(enable), .display_on(display_on),
    .brightness(brightness), .seg_data(seg_data), .keys(keys_b), .keys_valid(keys_valid_b),
    .busy(busy_b), .stb(stb_b), .dev_clk(dev_clk_b), .dio_out(dio_out_b), .dio_oe(dio_oe_b),
    .dio_in(dio_in_b)
  );

  typedef struct {
    logic [135:0] data;
    int           nbits;
    int           low;
    int           nrd;
    int           gap;
  } txn_t;

  txn_t        txn_q[$];
  logic [31:0] keys_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] board_keys = 32'd0;
  int          rd_idx = 0;
  int          stb_falls_a = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected frame built straight from the protocol description.
  task automatic push_frame(input logic [127:0] seg, input logic [2:0] bri, input logic don,
                            input logic [31:0] kb);
    txn_t t;
    t.data = 136'h40; t.nbits = 8; t.low = 17; t.nrd = 0; t.gap = -1;
    txn_q.push_back(t);
    t.data = {seg, 8'hC0}; t.nbits = 136; t.low = 1 + 17 * 16; t.gap = 2;
    txn_q.push_back(t);
    t.data = {128'd0, 8'h80 | (8'(don) << 3) | 8'(bri)}; t.nbits = 8; t.low = 17;
    txn_q.push_back(t);
    t.data = 136'h42; t.nbits = 8; t.low = 81 + TWAIT_A; t.nrd = 32;
    txn_q.push_back(t);
    keys_q.push_back(kb);
  endtask

  task automatic apply_frame(input logic [127:0] seg, input logic [2:0] bri, input logic don,
                             input logic [31:0] kb);
    seg_data   = seg;
    brightness = bri;
    display_on = don;
    board_keys = kb;
    push_frame(seg, bri, don, kb);
  endtask

  task automatic step();
    @(posedge drvclk);
    #2;
  endtask

  task automatic wait_kv(input int maxc);
    bit got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge drvclk);
      if (keys_valid_a) got = 1'b1;
    end
    check("kv_timeout", 136'(got), 136'(1));
  endtask

  task automatic wait_busy(input int maxc);
    bit got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge drvclk);
      if (busy_a) got = 1'b1;
    end
    check("busy_timeout", 136'(got), 136'(1));
  endtask

  // Board model: drives key bits LSB first on each falling CLK while DIO is released.
  initial forever begin
    @(negedge stb_a);
    rd_idx = 0;
  end

  initial forever begin
    @(negedge dev_clk_a);
    if (!dio_oe_a && rd_idx < 32) begin
      dio_in_a = board_keys[rd_idx];
      rd_idx++;
    end
  end

  // Bus monitor for the main instance.
  logic [135:0] cap;
  int           nb, nrd, low_cnt, high_cnt, gap_seen;
  logic         prev_stb, prev_clk, prev_kv;
  txn_t         et;

  initial begin
    prev_stb = 1'b1; prev_clk = 1'b1; prev_kv = 1'b0;
    high_cnt = 0; gap_seen = 0; low_cnt = 0; nb = 0; nrd = 0; cap = '0;
    forever begin
      @(negedge drvclk);
      if (!reset_n) begin
        prev_stb = 1'b1; prev_clk = 1'b1; prev_kv = 1'b0; high_cnt = 0;
      end else begin
        if (prev_stb && !stb_a) begin
          check("clk_at_stb_fall", 136'({prev_clk, dev_clk_a}), 136'(2'b11));
          gap_seen = high_cnt;
          low_cnt = 0; nb = 0; nrd = 0; cap = '0;
          stb_falls_a++;
        end
        if (!stb_a) begin
          low_cnt++;
          if (!prev_clk && dev_clk_a) begin
            if (dio_oe_a) begin
              if (nb < 136) cap[nb] = dio_out_a;
              nb++;
            end else begin
              nrd++;
            end
          end
        end
        if (!prev_stb && stb_a) begin
          check("clk_at_stb_rise", 136'({prev_clk, dev_clk_a}), 136'(2'b11));
          high_cnt = 0;
          if (txn_q.size() == 0) begin
            check("txn_unexpected", 136'(1), 136'(0));
          end else begin
            et = txn_q.pop_front();
            check("txn_bytes", cap, et.data);
            check("txn_nbits", 136'(nb), 136'(et.nbits));
            check("stb_low_cycles", 136'(low_cnt), 136'(et.low));
            check("read_bits_released", 136'(nrd), 136'(et.nrd));
            if (et.gap >= 0) check("gap_cycles", 136'(gap_seen), 136'(et.gap));
          end
        end
        if (stb_a) high_cnt++;
        if (keys_valid_a) begin
          check("busy_at_kv", 136'(busy_a), 136'(1));
          if (keys_q.size() == 0) check("kv_unexpected", 136'(1), 136'(0));
          else check("keys", 136'(keys_a), 136'(keys_q.pop_front()));
        end
        if (prev_kv) begin
          check("kv_one_cycle", 136'(keys_valid_a), 136'(0));
          check("busy_after_kv", 136'(busy_a), 136'(0));
        end
        prev_stb = stb_a;
        prev_clk = dev_clk_a;
        prev_kv  = keys_valid_a;
      end
    end
  end

  // Zero-gap monitor: busy drops for one cycle, then the next frame starts if enabled.
  int   stage_b;
  logic en_cap;

  initial begin
    stage_b = 0; en_cap = 1'b0;
    forever begin
      @(negedge drvclk);
      if (!reset_n) begin
        stage_b = 0;
      end else if (keys_valid_b) begin
        check("b_keys", 136'(keys_b), 136'(32'hFFFF_FFFF));
        check("b_busy_at_kv", 136'(busy_b), 136'(1));
        stage_b = 1;
      end else if (stage_b == 1) begin
        check("b_busy_after_kv", 136'(busy_b), 136'(0));
        en_cap  = enable;
        stage_b = 2;
      end else if (stage_b == 2) begin
        check("b_restart_stb", 136'(stb_b), 136'(!en_cap));
        stage_b = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] s;
    logic [31:0]  prev_kb;
    int           falls0;

    reset_n = 1'b0; enable = 1'b0; seg_data = '0; brightness = '0; display_on = 1'b0;
    repeat (3) step();
    check("rst_stb", 136'(stb_a), 136'(1));
    check("rst_dev_clk", 136'(dev_clk_a), 136'(1));
    check("rst_dio_oe", 136'(dio_oe_a), 136'(0));
    check("rst_dio_out", 136'(dio_out_a), 136'(1));
    check("rst_keys", 136'(keys_a), 136'(0));
    check("rst_kv", 136'(keys_valid_a), 136'(0));
    check("rst_busy", 136'(busy_a), 136'(0));
    reset_n = 1'b1;
    repeat (10) step();
    check("disabled_stb", 136'(stb_a), 136'(1));
    check("disabled_busy", 136'(busy_a), 136'(0));

    // Fixed frame: byte k = k, full brightness, known key bytes.
    for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(k);
    apply_frame(s, 3'd7, 1'b1, 32'h8100_3CA5);
    enable = 1'b1;
    wait_kv(1500);

    repeat (3) begin
      step();
      apply_frame({$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom);
      wait_kv(1500);
    end

    // Image change mid-T_DATA only affects the following frame.
    step();
    prev_kb = board_keys;
    apply_frame({$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom);
    wait_busy(200);
    repeat (40) step();
    check("keys_hold_midframe", 136'(keys_a), 136'(prev_kb));
    apply_frame({$urandom, $urandom, $urandom, $urandom}, brightness, display_on, board_keys);
    wait_kv(1500);
    wait_kv(1500);

    // Asynchronous reset in the middle of T_DATA.
    step();
    apply_frame({$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom);
    wait_busy(200);
    repeat (40) step();
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_stb", 136'(stb_a), 136'(1));
    check("arst_dev_clk", 136'(dev_clk_a), 136'(1));
    check("arst_dio_oe", 136'(dio_oe_a), 136'(0));
    check("arst_keys", 136'(keys_a), 136'(0));
    check("arst_busy", 136'(busy_a), 136'(0));
    check("arst_b_keys", 136'(keys_b), 136'(0));
    txn_q.delete();
    keys_q.delete();
    apply_frame({$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom);
    repeat (3) step();
    reset_n = 1'b1;
    wait_kv(1500);

    // Drop enable during T_CTRL: frame completes, then the bus stays idle.
    step();
    apply_frame({$urandom, $urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom);
    wait_busy(200);
    repeat (299) step();
    enable = 1'b0;
    wait_kv(1500);
    falls0 = stb_falls_a;
    repeat (2 * int'(GAP_A) + 20) step();
    check("idle_no_new_frame", 136'(stb_falls_a), 136'(falls0));
    check("idle_stb", 136'(stb_a), 136'(1));
    check("idle_busy", 136'(busy_a), 136'(0));

    repeat (5) step();
    check("txn_queue_drained", 136'(txn_q.size()), 136'(0));
    check("keys_queue_drained", 136'(keys_q.size()), 136'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
